// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, func3, FSM-state constants and access-size helpers
package cpu_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ITYPE  = 5'b00100;
    localparam logic [4:0] OP_RTYPE  = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_REQ  = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Stores treat unknown func3 as SW; loads treat unknown func3 as LW.
    function automatic size_e access_size(input logic is_store, input logic [2:0] func3);
        size_e sz;
        if (is_store) begin
            case (func3)
                F3_B:    sz = SZ_BYTE;
                F3_H:    sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (func3)
                F3_B, F3_BU: sz = SZ_BYTE;
                F3_H, F3_HU: sz = SZ_HALF;
                default:     sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] addr);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr[0];
            SZ_WORD: mis = |addr;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute, data-memory and writeback signals of the memory stage
interface mem_stage_if;

    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    modport master (
        input  ex_valid, ex_opcode, ex_func3, ex_alu_out, ex_rs2_data, ex_rd, ex_regwrite,
        output ex_ready,
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        output wb_valid, wb_regwrite, wb_rd, wb_data, misalign
    );

    modport slave (
        output ex_valid, ex_opcode, ex_func3, ex_alu_out, ex_rs2_data, ex_rd, ex_regwrite,
        input  ex_ready,
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        input  wb_valid, wb_regwrite, wb_rd, wb_data, misalign
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - load byte/half selection and sign/zero extension
module load_ext
    import cpu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[{addr, 3'b000} +: 8];
        sel_half = addr[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   data = {24'd0, sel_byte};
            F3_H:    data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   data = {16'd0, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: load/store sequencing and writeback
module mem_stage
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.master  bus
);

    logic [1:0]  state;
    logic [2:0]  cap_func3;
    logic [1:0]  cap_addr;
    logic [4:0]  cap_rd;
    logic        cap_regwrite;

    logic        is_load;
    logic        is_store;
    size_e       size;
    logic        mis;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign bus.ex_ready = (state == ST_IDLE);

    always_comb begin
        is_load  = (bus.ex_opcode == OP_LOAD);
        is_store = (bus.ex_opcode == OP_STORE);
        size     = access_size(is_store, bus.ex_func3);
        mis      = is_misaligned(size, bus.ex_alu_out[1:0]);
        case (size)
            SZ_BYTE: begin
                st_wstrb = 4'b0001 << bus.ex_alu_out[1:0];
                st_wdata = {4{bus.ex_rs2_data[7:0]}};
            end
            SZ_HALF: begin
                st_wstrb = bus.ex_alu_out[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.ex_rs2_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = bus.ex_rs2_data;
            end
        endcase
    end

    load_ext u_load_ext (
        .func3 (cap_func3),
        .addr  (cap_addr),
        .rdata (bus.dm_rdata),
        .data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cap_func3       <= 3'd0;
            cap_addr        <= 2'd0;
            cap_rd          <= 5'd0;
            cap_regwrite    <= 1'b0;
            bus.dm_req      <= 1'b0;
            bus.dm_we       <= 1'b0;
            bus.dm_addr     <= 32'd0;
            bus.dm_wstrb    <= 4'd0;
            bus.dm_wdata    <= 32'd0;
            bus.wb_valid    <= 1'b0;
            bus.wb_regwrite <= 1'b0;
            bus.wb_rd       <= 5'd0;
            bus.wb_data     <= 32'd0;
            bus.misalign    <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            bus.misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ex_valid) begin
                        if (is_load || is_store) begin
                            cap_func3    <= bus.ex_func3;
                            cap_addr     <= bus.ex_alu_out[1:0];
                            cap_rd       <= bus.ex_rd;
                            cap_regwrite <= bus.ex_regwrite;
                            if (mis) begin
                                bus.wb_valid    <= 1'b1;
                                bus.wb_regwrite <= 1'b0;
                                bus.wb_rd       <= bus.ex_rd;
                                bus.wb_data     <= bus.ex_alu_out;
                                bus.misalign    <= 1'b1;
                            end else begin
                                state        <= ST_MEM_REQ;
                                bus.dm_req   <= 1'b1;
                                bus.dm_we    <= is_store;
                                bus.dm_addr  <= {bus.ex_alu_out[31:2], 2'b00};
                                bus.dm_wstrb <= is_store ? st_wstrb : 4'd0;
                                bus.dm_wdata <= is_store ? st_wdata : 32'd0;
                            end
                        end else begin
                            bus.wb_valid    <= 1'b1;
                            bus.wb_regwrite <= bus.ex_regwrite;
                            bus.wb_rd       <= bus.ex_rd;
                            bus.wb_data     <= bus.ex_alu_out;
                        end
                    end
                end
                ST_MEM_REQ: begin
                    // Request fields stay frozen until the grant arrives.
                    if (bus.dm_gnt) begin
                        bus.dm_req <= 1'b0;
                        if (bus.dm_we) begin
                            state           <= ST_IDLE;
                            bus.wb_valid    <= 1'b1;
                            bus.wb_regwrite <= 1'b0;
                            bus.wb_rd       <= cap_rd;
                        end else begin
                            state <= ST_MEM_WAIT;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dm_rvalid) begin
                        state           <= ST_IDLE;
                        bus.wb_valid    <= 1'b1;
                        bus.wb_regwrite <= cap_regwrite;
                        bus.wb_rd       <= cap_rd;
                        bus.wb_data     <= ld_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    // Expected outputs after the next rising edge
    logic        e_ready, e_req, e_we, e_wb_valid, e_wb_regwrite, e_misalign;
    logic [31:0] e_addr, e_wdata, e_wb_data;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_wb_rd;
    bit          e_full, e_chk_data;

    // Outstanding memory operation as seen by the model
    bit          pend, granted, m_st, m_rw;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [4:0]  m_rd;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int msize(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
        int sz;
        logic [31:0] v;
        sz = msize(1'b0, f3);
        if (sz == 4) return rd;
        v = (rd >> (8 * (a % 4))) & ((32'd1 << (8 * sz)) - 32'd1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (32'd1 << (8 * sz - 1)))
            v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    task automatic model_step();
        int sz;
        e_wb_valid = 1'b0;
        e_misalign = 1'b0;
        e_full     = 1'b0;
        if (rst) begin
            pend = 0; granted = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wstrb = 0; e_wdata = 0;
            e_wb_regwrite = 0; e_wb_rd = 0; e_wb_data = 0;
            e_full = 1;
        end else if (!pend) begin
            if (bus.ex_valid) begin
                if (bus.ex_opcode == OP_LOAD || bus.ex_opcode == OP_STORE) begin
                    m_st = (bus.ex_opcode == OP_STORE);
                    sz = msize(m_st, bus.ex_func3);
                    if (bus.ex_alu_out % sz != 0) begin
                        e_wb_valid = 1; e_wb_regwrite = 0; e_misalign = 1; e_chk_data = 0;
                    end else begin
                        pend = 1; granted = 0;
                        m_f3 = bus.ex_func3; m_addr = bus.ex_alu_out;
                        m_rd = bus.ex_rd; m_rw = bus.ex_regwrite;
                        e_req = 1; e_we = m_st;
                        e_addr = bus.ex_alu_out & ~32'd3;
                        if (m_st) begin
                            e_wstrb = 4'(((1 << sz) - 1) << (bus.ex_alu_out % 4));
                            e_wdata = (sz == 1) ? bus.ex_rs2_data[7:0] * 32'h01010101 :
                                      (sz == 2) ? bus.ex_rs2_data[15:0] * 32'h00010001 :
                                                  bus.ex_rs2_data;
                        end
                    end
                end else begin
                    e_wb_valid = 1; e_wb_regwrite = bus.ex_regwrite;
                    e_wb_rd = bus.ex_rd; e_wb_data = bus.ex_alu_out; e_chk_data = 1;
                end
            end
        end else if (!granted) begin
            if (bus.dm_gnt) begin
                e_req = 0;
                if (m_st) begin
                    pend = 0; e_wb_valid = 1; e_wb_regwrite = 0; e_chk_data = 0;
                end else begin
                    granted = 1;
                end
            end
        end else if (bus.dm_rvalid) begin
            pend = 0;
            e_wb_valid = 1; e_wb_regwrite = m_rw; e_wb_rd = m_rd;
            e_wb_data = mload(m_f3, m_addr, bus.dm_rdata); e_chk_data = 1;
        end
        e_ready = !pend;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("ex_ready", bus.ex_ready, e_ready);
            cmp("dm_req", bus.dm_req, e_req);
            cmp("wb_valid", bus.wb_valid, e_wb_valid);
            cmp("misalign", bus.misalign, e_misalign);
            if (e_req || e_full) begin
                cmp("dm_we", bus.dm_we, e_we);
                cmp("dm_addr", bus.dm_addr, e_addr);
            end
            if ((e_req && e_we) || e_full) begin
                cmp("dm_wstrb", bus.dm_wstrb, e_wstrb);
                cmp("dm_wdata", bus.dm_wdata, e_wdata);
            end
            if (e_wb_valid || e_full) cmp("wb_regwrite", bus.wb_regwrite, e_wb_regwrite);
            if ((e_wb_valid && e_chk_data) || e_full) begin
                cmp("wb_rd", bus.wb_rd, e_wb_rd);
                cmp("wb_data", bus.wb_data, e_wb_data);
            end
        end
    end

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive_ex(input bit v, input logic [4:0] op, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [4:0] rd, input bit rw);
        bus.ex_valid = v; bus.ex_opcode = op; bus.ex_func3 = f3;
        bus.ex_alu_out = alu; bus.ex_rs2_data = rs2; bus.ex_rd = rd; bus.ex_regwrite = rw;
    endtask

    task automatic drive_mem(input bit g, input bit rv, input logic [31:0] rd);
        bus.dm_gnt = g; bus.dm_rvalid = rv; bus.dm_rdata = rd;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                            input logic [31:0] want, input string nm);
        drive_ex(1, OP_LOAD, f3, a, 0, 5'd7, 1); drive_mem(0, 0, 0);
        step();
        drive_ex(0, 0, 0, 0, 0, 0, 0); drive_mem(1, 0, 0);
        step();
        drive_mem(0, 1, rdata);
        step();
        drive_mem(0, 0, 0);
        cmp({nm, "_valid"}, bus.wb_valid, 1);
        cmp({nm, "_data"}, bus.wb_data, want);
    endtask

    initial begin
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        drive_mem(0, 0, 0);
        cmp("model_lb", mload(F3_B, 32'h101, 32'h0000_8000), 32'hFFFF_FF80);
        cmp("model_lhu", mload(F3_HU, 32'h102, 32'hBEEF_0000), 32'h0000_BEEF);
        cmp("model_lh", mload(F3_H, 32'h100, 32'h0000_8001), 32'hFFFF_8001);
        armed = 1'b1;
        rst = 1'b1;
        step();
        cmp("rst_ready", bus.ex_ready, 1);
        rst = 1'b0;
        step();

        // ADD result, then back-to-back non-memory ops
        drive_ex(1, OP_RTYPE, 0, 32'h10, 0, 5'd3, 1);
        step();
        cmp("add_valid", bus.wb_valid, 1);
        cmp("add_data", bus.wb_data, 32'h10);
        cmp("add_noreq", bus.dm_req, 0);
        drive_ex(1, OP_ITYPE, 0, 32'h55, 0, 5'd4, 1);
        step();
        cmp("b2b_data", bus.wb_data, 32'h55);

        // SB with delayed grant
        drive_ex(1, OP_STORE, F3_B, 32'h103, 32'hAB, 5'd0, 0);
        step();
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cmp("sb_addr", bus.dm_addr, 32'h100);
            cmp("sb_wstrb", bus.dm_wstrb, 4'b1000);
            cmp("sb_wdata", bus.dm_wdata, 32'hABAB_ABAB);
            cmp("sb_req", bus.dm_req, 1);
            cmp("sb_ready", bus.ex_ready, 0);
            step();
        end
        drive_mem(1, 0, 0);
        step();
        drive_mem(0, 0, 0);
        cmp("sb_wb_valid", bus.wb_valid, 1);
        cmp("sb_wb_rw", bus.wb_regwrite, 0);
        cmp("sb_req_off", bus.dm_req, 0);

        run_load(F3_B, 32'h101, 32'h0000_8000, 32'hFFFF_FF80, "lb");
        run_load(F3_BU, 32'h101, 32'h0000_8000, 32'h0000_0080, "lbu");
        run_load(F3_HU, 32'h102, 32'hBEEF_0000, 32'h0000_BEEF, "lhu");

        // Misaligned LW
        drive_ex(1, OP_LOAD, F3_W, 32'h102, 0, 5'd9, 1);
        step();
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        cmp("mis_pulse", bus.misalign, 1);
        cmp("mis_rw", bus.wb_regwrite, 0);
        cmp("mis_noreq", bus.dm_req, 0);
        step();
        cmp("mis_single", bus.misalign, 0);

        // Reset while waiting for load data
        drive_ex(1, OP_LOAD, F3_W, 32'h100, 0, 5'd5, 1);
        step();
        drive_ex(0, 0, 0, 0, 0, 0, 0); drive_mem(1, 0, 0);
        step();
        drive_mem(0, 0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst_noreq", bus.dm_req, 0);
        drive_mem(0, 1, 32'h1234_5678);
        step();
        drive_mem(0, 0, 0);
        cmp("rst_nowb", bus.wb_valid, 0);
        cmp("rst_ready_after", bus.ex_ready, 1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [4:0]  op;
            logic [31:0] a;
            int          r;
            r = $urandom_range(0, 5);
            op = (r <= 1) ? OP_LOAD : (r == 2) ? OP_STORE : (r == 3) ? OP_RTYPE :
                 (r == 4) ? OP_ITYPE : 5'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            drive_ex($urandom_range(0, 9) < 7, op, 3'($urandom), a, $urandom,
                     5'($urandom), 1'($urandom));
            bus.dm_gnt    = ($urandom_range(0, 9) < 4);
            bus.dm_rvalid = !bus.dm_gnt && ($urandom_range(0, 9) < 3);
            bus.dm_rdata  = $urandom;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
